// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared constants and state encodings for the calculator converters
package calc_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    B2D_IDLE  = 2'b00,
    B2D_ADD3  = 2'b01,
    B2D_SHIFT = 2'b10,
    B2D_DONE  = 2'b11
  } b2d_state_t;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// rtl/bin2bcd_seq_if.sv - init/done start-finish handshake bundle for the binary-to-BCD converter
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);

  logic                  init;
  logic [WIDTH-1:0]      bin_in;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  busy;
  logic                  done;

  modport master (output init, bin_in, input bcd_out, busy, done);
  modport slave  (input init, bin_in, output bcd_out, busy, done);

endinterface

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - single-digit double-dabble corrector
module bcd_add3
  import calc_pkg::*;
(
  input  logic [BCD_W-1:0] i_digit,
  output logic [BCD_W-1:0] o_digit
);

  assign o_digit = (i_digit >= BCD_W'(5)) ? i_digit + BCD_W'(3) : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-and-add-3 binary-to-BCD converter, one bit per two clocks
module bin2bcd_seq
  import calc_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DIGITS    = 5,
  parameter int DONE_HOLD = 31
) (
  input  logic         clk,
  input  logic         rst,
  bin2bcd_seq_if.slave bus
);

  localparam int BCD_BITS = BCD_W * DIGITS;
  localparam int CNT_W    = $clog2(WIDTH);
  localparam int HOLD_W   = $clog2(DONE_HOLD + 1);

  b2d_state_t          r_state;
  b2d_state_t          w_next_state;
  logic [WIDTH-1:0]    r_bin_sr;
  logic [BCD_BITS-1:0] r_bcd_sr;
  logic [BCD_BITS-1:0] r_bcd_out;
  logic [BCD_BITS-1:0] w_bcd_adj;
  logic [BCD_BITS-1:0] w_bcd_shift;
  logic [CNT_W-1:0]    r_cnt;
  logic [HOLD_W-1:0]   r_hold;
  logic                w_last_bit;
  logic                w_hold_end;
  logic                w_busy;
  logic                w_done;

  for (genvar k = 0; k < DIGITS; k++) begin : g_add3
    bcd_add3 u_add3 (
      .i_digit (r_bcd_sr[BCD_W*k +: BCD_W]),
      .o_digit (w_bcd_adj[BCD_W*k +: BCD_W])
    );
  end

  // The top bcd bit falls off here; the DIGITS sizing guarantees it is always zero.
  assign w_bcd_shift = {r_bcd_sr[BCD_BITS-2:0], r_bin_sr[WIDTH-1]};
  assign w_last_bit  = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_hold_end  = (r_hold == HOLD_W'(DONE_HOLD - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= B2D_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = B2D_IDLE;
    case (r_state)
      B2D_IDLE:  w_next_state = bus.init ? B2D_ADD3 : B2D_IDLE;
      B2D_ADD3:  w_next_state = B2D_SHIFT;
      B2D_SHIFT: w_next_state = w_last_bit ? B2D_DONE : B2D_ADD3;
      B2D_DONE:  w_next_state = w_hold_end ? B2D_IDLE : B2D_DONE;
      default:   w_next_state = B2D_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      B2D_ADD3, B2D_SHIFT: w_busy = 1'b1;
      B2D_DONE:            w_done = 1'b1;
      default:             ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bin_sr  <= '0;
      r_bcd_sr  <= '0;
      r_bcd_out <= '0;
      r_cnt     <= '0;
      r_hold    <= '0;
    end else begin
      case (r_state)
        B2D_IDLE: begin
          if (bus.init) begin
            r_bin_sr <= bus.bin_in;
            r_bcd_sr <= '0;
            r_cnt    <= '0;
          end
        end
        B2D_ADD3: r_bcd_sr <= w_bcd_adj;
        B2D_SHIFT: begin
          r_bcd_sr <= w_bcd_shift;
          r_bin_sr <= {r_bin_sr[WIDTH-2:0], 1'b0};
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last_bit) begin
            r_bcd_out <= w_bcd_shift;
          end
        end
        B2D_DONE: r_hold <= w_hold_end ? '0 : r_hold + HOLD_W'(1);
        default: ;
      endcase
    end
  end

  assign bus.bcd_out = r_bcd_out;
  assign bus.busy    = w_busy;
  assign bus.done    = w_done;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - randomized self-checking bench for bin2bcd_seq against a decimal-string model
module tb_bin2bcd_seq;

  localparam int WIDTH     = 16;
  localparam int DIGITS    = 5;
  localparam int DONE_HOLD = 31;
  localparam int LAT       = 2 * WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  bin2bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS), .DONE_HOLD(DONE_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Decimal digits straight from the printed number, packed one digit per nibble.
  function automatic logic [19:0] ref_bcd(input int unsigned v);
    string s;
    logic [19:0] r;
    r = '0;
    s = $sformatf("%0d", v);
    for (int i = 0; i < s.len(); i++) r = {r[15:0], 4'(s[i] - 8'd48)};
    return r;
  endfunction

  task automatic wait_done(input string tag, input logic [15:0] v, input bit glitch);
    int cyc;
    int busy_n;
    bit both;
    cyc = 0; busy_n = 0; both = 0;
    while (!bus.done && cyc < 200) begin
      if (bus.busy) busy_n++;
      if (glitch && cyc == 5) begin
        bus.bin_in = 16'd123;
        bus.init   = 1'b1;
      end else if (glitch && cyc == 6) begin
        bus.init = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'(LAT));
    check({tag, " busy_cycles"}, 32'(busy_n), 32'(LAT));
    check({tag, " bcd_out"}, 32'(bus.bcd_out), 32'(ref_bcd(32'(v))));
  endtask

  task automatic drain_done(input string tag);
    int done_n;
    bit both;
    done_n = 0; both = 0;
    while (bus.done && done_n < 100) begin
      if (bus.busy) both = 1'b1;
      done_n++;
      @(negedge clk);
    end
    check({tag, " done_cycles"}, 32'(done_n), 32'(DONE_HOLD));
    check({tag, " busy_and_done"}, 32'(both), 32'(0));
  endtask

  task automatic convert(input logic [15:0] v, input bit glitch, input string tag);
    @(negedge clk);
    bus.bin_in = v;
    bus.init   = 1'b1;
    @(negedge clk);
    bus.init   = 1'b0;
    wait_done(tag, v, glitch);
    drain_done(tag);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v1, v2;
    bus.init   = 1'b0;
    bus.bin_in = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'(0));
    check("reset done", 32'(bus.done), 32'(0));
    check("reset bcd_out", 32'(bus.bcd_out), 32'(0));
    rst = 1'b1;

    convert(16'd0, 1'b0, "zero");
    convert(16'd255, 1'b0, "d255");
    convert(16'hFFFF, 1'b0, "max");
    convert(16'd9999, 1'b0, "d9999");
    convert(16'd4096, 1'b1, "reinit");
    repeat (4) @(negedge clk);
    check("reinit ignored busy", 32'(bus.busy), 32'(0));
    check("reinit ignored bcd_out", 32'(bus.bcd_out), 32'h04096);

    // Asynchronous reset in the middle of a conversion.
    @(negedge clk);
    bus.bin_in = 16'd500;
    bus.init   = 1'b1;
    @(negedge clk);
    bus.init   = 1'b0;
    repeat (9) @(negedge clk);
    check("pre-abort busy", 32'(bus.busy), 32'(1));
    #2 rst = 1'b0;
    #1;
    check("abort busy", 32'(bus.busy), 32'(0));
    check("abort done", 32'(bus.done), 32'(0));
    check("abort bcd_out", 32'(bus.bcd_out), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    convert(16'd777, 1'b0, "post-reset");

    // init held high: back-to-back conversions with a single IDLE cycle between.
    v1 = 16'($urandom_range(0, 65535));
    v2 = 16'($urandom_range(0, 65535));
    @(negedge clk);
    bus.bin_in = v1;
    bus.init   = 1'b1;
    @(negedge clk);
    wait_done("held1", v1, 1'b0);
    bus.bin_in = v2;
    drain_done("held1");
    check("held idle busy", 32'(bus.busy), 32'(0));
    check("held idle done", 32'(bus.done), 32'(0));
    @(negedge clk);
    check("held restart busy", 32'(bus.busy), 32'(1));
    bus.init = 1'b0;
    wait_done("held2", v2, 1'b0);
    drain_done("held2");

    for (int i = 0; i < 1000; i++) begin
      convert(16'($urandom_range(0, 65535)), 1'b0, $sformatf("sweep%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
